// File: rtl/bcd_counter_pkg.sv
// Shared constants, types and helpers for the counter chain and other
// button-driven blocks.
package bcd_counter_pkg;

    localparam int DEF_MOD        = 10;
    localparam int DEF_DEB_CYCLES = 10000;

    typedef struct packed {
        logic [31:0] deb_cycles;
        logic        btn_idle;
    } deb_cfg_t;

    localparam deb_cfg_t DEF_DEB_CFG = '{deb_cycles: 32'(DEF_DEB_CYCLES), btn_idle: 1'b0};

    // Bits needed to hold values 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Control/data bundle between the board-facing logic and the counter chain.
interface bcd_counter_chain_if #(
    parameter int N_DIGITS = 4,
    parameter int DW       = 4
);
    logic                   btn_raw;
    logic                   cascade_in;
    logic                   cnt_en;
    logic                   up;
    logic                   r0a;
    logic                   r0b;
    logic                   r9a;
    logic                   r9b;
    logic                   load;
    logic [N_DIGITS*DW-1:0] load_val;
    logic [N_DIGITS*DW-1:0] count_q;
    logic                   tc_pulse;

    modport master (
        output btn_raw, cascade_in, cnt_en, up, r0a, r0b, r9a, r9b, load, load_val,
        input  count_q, tc_pulse
    );

    modport slave (
        input  btn_raw, cascade_in, cnt_en, up, r0a, r0b, r9a, r9b, load, load_val,
        output count_q, tc_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle press pulse when
// the debounced level leaves the idle level.
module btn_debounce
    import bcd_counter_pkg::*;
#(
    parameter int   DEB_CYCLES = DEF_DEB_CYCLES,
    parameter logic BTN_IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_evt
);
    localparam int            CW       = clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          deb_level;
    logic          prev_level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= BTN_IDLE;
            sync2 <= BTN_IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Level is only accepted after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level  <= BTN_IDLE;
            prev_level <= BTN_IDLE;
            cnt        <= '0;
        end else begin
            prev_level <= deb_level;
            if (sync2 == deb_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_level <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press_evt = (deb_level != BTN_IDLE) && (prev_level == BTN_IDLE);

endmodule

// File: rtl/bcd_counter_chain.sv
// N-digit cascaded modulo-MOD up/down counter with clear/preset gates,
// clamped parallel load and a registered whole-chain wrap pulse.
module bcd_counter_chain
    import bcd_counter_pkg::*;
#(
    parameter int   N_DIGITS   = 4,
    parameter int   MOD        = DEF_MOD,
    parameter int   DEB_CYCLES = DEF_DEB_CYCLES,
    parameter logic BTN_IDLE   = 1'b0
) (
    input logic                clk,
    input logic                rst,
    bcd_counter_chain_if.slave bus
);
    localparam int            DW    = clog2(MOD);
    localparam logic [DW-1:0] DMAX  = DW'(MOD - 1);
    localparam logic [DW:0]   MOD_X = (DW + 1)'(MOD);

    logic                         press_evt;
    logic                         evt;
    logic                         r9;
    logic                         r0;
    logic                         ovr;
    logic                         tc_q;
    logic [N_DIGITS:0]            carry_up;
    logic [N_DIGITS:0]            borrow_dn;
    logic [N_DIGITS-1:0][DW-1:0]  digit;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .BTN_IDLE   (BTN_IDLE)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (bus.btn_raw),
        .press_evt (press_evt)
    );

    assign r9  = bus.r9a & bus.r9b;
    assign r0  = bus.r0a & bus.r0b;
    assign ovr = r9 | r0 | bus.load;
    assign evt = (press_evt | bus.cascade_in) & bus.cnt_en;

    assign carry_up[0]  = 1'b1;
    assign borrow_dn[0] = 1'b1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        logic [DW-1:0] digit_r;
        logic [DW-1:0] stepped;
        logic [DW-1:0] lv;
        logic [DW-1:0] lv_clamped;

        assign lv         = bus.load_val[g*DW +: DW];
        assign lv_clamped = ({1'b0, lv} >= MOD_X) ? DMAX : lv;

        assign carry_up[g+1]  = carry_up[g]  & (digit_r == DMAX);
        assign borrow_dn[g+1] = borrow_dn[g] & (digit_r == '0);

        // Out-of-range codes fold back to a legal value on the next step.
        always_comb begin
            stepped = digit_r;
            if (bus.up) begin
                stepped = (digit_r >= DMAX) ? '0 : digit_r + DW'(1);
            end else begin
                stepped = (digit_r == '0 || digit_r > DMAX) ? DMAX : digit_r - DW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                digit_r <= '0;
            end else if (r9) begin
                digit_r <= DMAX;
            end else if (r0) begin
                digit_r <= '0;
            end else if (bus.load) begin
                digit_r <= lv_clamped;
            end else if (evt && (bus.up ? carry_up[g] : borrow_dn[g])) begin
                digit_r <= stepped;
            end
        end

        assign digit[g] = digit_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= evt & ~ovr & (bus.up ? carry_up[N_DIGITS] : borrow_dn[N_DIGITS]);
        end
    end

    assign bus.count_q  = digit;
    assign bus.tc_pulse = tc_q;

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
- Parametrised multi-digit modulo counter, successor to the single 2/5/10 counter.
- N_DIGITS cascaded digits of modulus MOD, counting up or down.
- Has R0 (clear) and R9 (preset-to-max) gate pairs, parallel load, and a terminal-count pulse.
- Count events come from an on-chip debounced push-button or from a one-cycle cascade strobe, so chains can be built across instances.
- Sits between board buttons/switches and the LED/seven-segment display logic.

Parameters:
- N_DIGITS, 4: number of cascaded digits (1..8).
- MOD, 10: modulus of every digit (2..16). DW = clog2(MOD) bits per digit.
- DEB_CYCLES, 10000: consecutive stable cycles required to accept a button level change (>=2).
- BTN_IDLE, 0: released level of btn_raw.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  1  unsynchronised push-button; a debounced press (BTN_IDLE -> !BTN_IDLE) is one count event
- cascade_in  in  1  one-cycle count strobe, already synchronous to clk
- cnt_en  in  1  count enable; gates count events only
- up  in  1  1 = count up, 0 = count down
- r0a, r0b  in  1  clear gate pair
- r9a, r9b  in  1  preset gate pair
- load  in  1  synchronous parallel load
- load_val  in  N_DIGITS*DW  load value; digit 0 in LSBs
- count_q  out  N_DIGITS*DW  counter value; digit 0 in LSBs
- tc_pulse  out  1  one-cycle pulse when the whole chain wraps

Behaviour:
- Reset: clock and reset are fixed as one clock `clk`, asynchronous active-high `rst`. While rst is asserted:
  - count_q = 0 and tc_pulse = 0.
  - Synchroniser flops and debounced level = BTN_IDLE; debounce counter = 0.
  - Reset mid-bounce or mid-count discards the pending event.
- Debounce path:
  - btn_raw passes through a 2-flop synchroniser.
  - The debounce counter increments while the synchronised level differs from the debounced level; it clears to 0 whenever they match.
  - When the counter reaches DEB_CYCLES-1 with the levels still differing, the debounced level takes the new value and the counter clears.
  - press_evt = debounced level moved BTN_IDLE -> !BTN_IDLE in this cycle (registered prev vs current).
  - Latency: a clean press updates count_q exactly DEB_CYCLES+3 clock edges after the btn_raw change.
  - A bounce shorter than DEB_CYCLES produces no event.
  - A release produces no event.
- Count event: evt = (press_evt | cascade_in) & cnt_en. Coincident press_evt and cascade_in count once.
- Per-cycle priority, highest first:
  1. R9: r9a & r9b. Every digit <= MOD-1 (MOD=10 gives 9...9).
  2. R0: r0a & r0b. All digits <= 0.
  3. load: digit i <= load_val digit i. A digit >= MOD is clamped to MOD-1.
  4. evt: count.
  5. Otherwise hold.
  - R0/R9/load are synchronous and ignore cnt_en.
  - An evt that coincides with R9/R0/load is dropped, not deferred.
- Up counting:
  - Digit 0 always steps.
  - Digit i steps only when all lower digits equal MOD-1.
  - A digit at MOD-1 wraps to 0.
- Down counting:
  - Digit i steps only when all lower digits equal 0.
  - A digit at 0 wraps to MOD-1.
- tc_pulse: registered; high for exactly the one cycle after an evt that takes the chain all-(MOD-1) -> all-0 (up) or all-0 -> all-(MOD-1) (down). Never asserted by R0, R9 or load. Feed it to the next instance's cascade_in.
- Digit values never leave 0..MOD-1 after reset.
- No illegal-state lockup.
- All outputs are registered.

Decomposition:
- Shared package bcd_counter_pkg holds:
  - clog2 function (DW derivation).
  - Default constants DEF_MOD=10, DEF_DEB_CYCLES=10000.
  - A debounce-config struct/typedef for reuse by other button-driven blocks.
- One sub-module, btn_debounce: holds the synchroniser, counter, debounced level and press pulse; parameters DEB_CYCLES and BTN_IDLE.
- Digit stepping stays in the top module as a generate loop over N_DIGITS.

Test Plan:
- Parameters N_DIGITS=2, MOD=10, DEB_CYCLES=4, up=1, cnt_en=1. Pulse cascade_in 99 times from reset -> count_q=0x99 (digits 9,9), tc_pulse=0. One more pulse -> count_q=0x00 and tc_pulse high for exactly one cycle.
- btn_raw bounces 0/1 every 2 cycles for 20 cycles, then holds 1 -> exactly one increment, landing at edge DEB_CYCLES+3 after the final rising edge. Release bounce -> no increment.
- Hold r9a=r9b=r0a=r0b=1 with cascade_in pulsing -> count_q stays 0x99. Drop r9b -> next edge count_q=0x00. No tc_pulse throughout.
- up=0 from 0x00, one cascade_in -> count_q=0x99, tc_pulse=1. Next pulse -> 0x98.
- load=1, load_val=0x3C (digit0=12, out of range) -> count_q=0x39. load coincident with cascade_in -> only the load is applied.
- Assert rst for one cycle mid-debounce (count 0x05, btn held pressed 2 cycles) -> count_q=0 immediately. The press completes only after a full new DEB_CYCLES window; cnt_en=0 then blocks it, count stays 0.
